x_demux_ddr_align: RTL and testbench

X_DEMUX_DDR_ALIGN -- requirements
Module: x_demux_ddr_align

---
 rtl/x_demux_ddr_align.sv | 168 ++++++++++++++++
 tb/tb_x_demux_ddr_align.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/x_demux_ddr_align.sv
// DDR input demultiplexer: splits an 80 MHz DDR stream into two 40 MHz slices,
// with a training FSM that picks the rise/fall pairing and a selectable output delay.
module x_demux_ddr_align #(
  parameter int unsigned         WIDTH     = 1,
  parameter int unsigned         MXDLY     = 3,
  parameter logic [2*WIDTH-1:0]  TRAIN_PAT = {WIDTH{2'b10}},
  parameter int unsigned         NMATCH    = 8,
  parameter int unsigned         TMO       = 255,
  localparam int unsigned        DW        = (MXDLY > 0) ? $clog2(MXDLY + 1) : 1
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic [WIDTH-1:0] din,
  input  logic             sset,
  input  logic [DW-1:0]    delay,
  input  logic             train_start,
  output logic [WIDTH-1:0] dout1st,
  output logic [WIDTH-1:0] dout2nd,
  output logic             swapped,
  output logic             train_busy,
  output logic             train_done,
  output logic             train_fail
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned TW = $clog2(TMO + 1);
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, SEARCH, LOCK, FAIL} state_t;

  logic [WIDTH-1:0] rise_q, fall_q, r1_q, f1_q, f1p_q;
  logic [PW-1:0]    stg_q [MXDLY+1];
  logic [DW-1:0]    dly_q, dly_nxt;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_n_q, cnt_n_d, cnt_s_q, cnt_s_d;
  logic          swapped_d, busy_d, done_d, fail_d;
  logic          match_n, match_s;

  // DDR capture: bare registers straight off the pin
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n)   rise_q <= '0;
    else if (sset) rise_q <= '1;
    else           rise_q <= din;
  end

  always_ff @(negedge clock or negedge aclr_n) begin
    if (!aclr_n)   fall_q <= '0;
    else if (sset) fall_q <= '1;
    else           fall_q <= din;
  end

  // Retime into the rising domain, pair the slices, then shift through the delay line
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r1_q  <= '0;
      f1_q  <= '0;
      f1p_q <= '0;
      for (int unsigned i = 0; i <= MXDLY; i++) stg_q[i] <= '0;
    end else if (sset) begin
      r1_q  <= '1;
      f1_q  <= '1;
      f1p_q <= '1;
      for (int unsigned i = 0; i <= MXDLY; i++) stg_q[i] <= '1;
    end else begin
      r1_q     <= rise_q;
      f1_q     <= fall_q;
      f1p_q    <= f1_q;
      stg_q[0] <= swapped ? {r1_q, f1p_q} : {f1_q, r1_q};
      for (int unsigned i = 1; i <= MXDLY; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  // Out-of-range delay requests saturate at the last tap
  always_comb begin
    dly_nxt = delay;
    if (32'(delay) > MXDLY) dly_nxt = DW'(MXDLY);
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) dly_q <= '0;
    else         dly_q <= dly_nxt;
  end

  assign {dout2nd, dout1st} = stg_q[dly_q];

  assign match_n = ({f1_q, r1_q} == TRAIN_PAT);
  assign match_s = ({r1_q, f1p_q} == TRAIN_PAT);

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      cnt_n_q    <= '0;
      cnt_s_q    <= '0;
      swapped    <= 1'b0;
      train_busy <= 1'b0;
      train_done <= 1'b0;
      train_fail <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_n_q    <= cnt_n_d;
      cnt_s_q    <= cnt_s_d;
      swapped    <= swapped_d;
      train_busy <= busy_d;
      train_done <= done_d;
      train_fail <= fail_d;
    end
  end

  // Training FSM: both pairings are scored in parallel; normal pairing wins ties
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_n_d   = cnt_n_q;
    cnt_s_d   = cnt_s_q;
    swapped_d = swapped;
    done_d    = train_done;
    fail_d    = train_fail;
    case (state_q)
      IDLE: begin
        if (train_start) begin
          state_d = SEARCH;
          timer_d = '0;
          cnt_n_d = '0;
          cnt_s_d = '0;
          done_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      SEARCH: begin
        if (train_start) begin
          timer_d = '0;
          cnt_n_d = '0;
          cnt_s_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
          if (!match_n)                     cnt_n_d = '0;
          else if (cnt_n_q != CW'(NMATCH))  cnt_n_d = cnt_n_q + CW'(1);
          if (!match_s)                     cnt_s_d = '0;
          else if (cnt_s_q != CW'(NMATCH))  cnt_s_d = cnt_s_q + CW'(1);
          if (cnt_n_q == CW'(NMATCH)) begin
            state_d   = LOCK;
            swapped_d = 1'b0;
          end else if (cnt_s_q == CW'(NMATCH)) begin
            state_d   = LOCK;
            swapped_d = 1'b1;
          end else if (timer_d == TW'(TMO)) begin
            state_d = FAIL;
          end
        end
      end
      LOCK: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      FAIL: begin
        state_d = IDLE;
        fail_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SEARCH);
  end

endmodule

// File: tb/tb_x_demux_ddr_align.sv
// Directed bench for x_demux_ddr_align: latency, delay taps, training lock/timeout,
// tie-break and reset/sset behaviour, with a slice history as the reference.
module tb_x_demux_ddr_align;

  logic       clock = 1'b0;
  logic       aclr_n, sset, train_start;
  logic [3:0] din;
  logic [1:0] delay;

  logic [3:0] d1_0, d2_0, d1_1, d2_1;
  logic       sw0, busy0, done0, fail0;
  logic       sw1, busy1, done1, fail1;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  logic [3:0] rh [1024];
  logic [3:0] fh [1024];

  x_demux_ddr_align #(
    .WIDTH(4), .MXDLY(3), .TRAIN_PAT(8'h5A), .NMATCH(8), .TMO(255)
  ) u0 (
    .clock(clock), .aclr_n(aclr_n), .din(din), .sset(sset), .delay(delay),
    .train_start(train_start), .dout1st(d1_0), .dout2nd(d2_0), .swapped(sw0),
    .train_busy(busy0), .train_done(done0), .train_fail(fail0)
  );

  x_demux_ddr_align #(
    .WIDTH(4), .MXDLY(3), .NMATCH(8), .TMO(255)
  ) u1 (
    .clock(clock), .aclr_n(aclr_n), .din(din), .sset(sset), .delay(delay),
    .train_start(train_start), .dout1st(d1_1), .dout2nd(d2_1), .swapped(sw1),
    .train_busy(busy1), .train_done(done1), .train_fail(fail1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: rise slice before the rising edge, fall slice before the falling edge
  task automatic step(input logic [3:0] r, input logic [3:0] f, input logic ts);
    rh[n] = r;
    fh[n] = f;
    din = r;
    train_start = ts;
    @(posedge clock);
    #2;
    train_start = 1'b0;
    din = f;
    @(negedge clock);
    #2;
    n++;
  endtask

  initial begin
    aclr_n = 1'b0;
    sset = 1'b0;
    train_start = 1'b0;
    din = 4'h0;
    delay = 2'd0;
    repeat (3) @(negedge clock);
    #2;
    chk("rst_d1", 8'(d1_0), 8'h0);
    chk("rst_d2", 8'(d2_0), 8'h0);
    chk("rst_sw", 8'(sw0), 8'h0);
    chk("rst_busy", 8'(busy0), 8'h0);
    chk("rst_done", 8'(done0), 8'h0);
    chk("rst_fail", 8'(fail0), 8'h0);
    aclr_n = 1'b1;

    // Constant A/5: visible two clocks after the first capture
    step(4'hA, 4'h5, 1'b0);
    step(4'hA, 4'h5, 1'b0);
    chk("lat_early_d1", 8'(d1_0), 8'h0);
    step(4'hA, 4'h5, 1'b0);
    chk("lat_d1", 8'(d1_0), 8'hA);
    chk("lat_d2", 8'(d2_0), 8'h5);

    for (int i = 0; i < 6; i++) begin
      step(4'(i + 1), 4'(14 - i), 1'b0);
      chk("d0_d1", 8'(d1_0), 8'(rh[n-3]));
      chk("d0_d2", 8'(d2_0), 8'(fh[n-3]));
    end
    delay = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step(4'(i + 7), 4'(8 - i), 1'b0);
      chk("d3_d1", 8'(d1_0), 8'(rh[n-6]));
      chk("d3_d2", 8'(d2_0), 8'(fh[n-6]));
    end
    delay = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step(4'(i + 3), 4'(13 - i), 1'b0);
      chk("d1_d1", 8'(d1_0), 8'(rh[n-4]));
    end
    delay = 2'(3'd7);
    for (int i = 0; i < 3; i++) begin
      step(4'(i + 9), 4'(2 + i), 1'b0);
      chk("d7_d1", 8'(d1_0), 8'(rh[n-6]));
      chk("d7_d2", 8'(d2_0), 8'(fh[n-6]));
    end
    delay = 2'd0;

    // Training pattern offset by half a cycle: only the swapped pairing matches
    repeat (5) step(4'h5, 4'hA, 1'b0);
    step(4'h5, 4'hA, 1'b1);
    chk("tr_busy", 8'(busy0), 8'h1);
    repeat (8) step(4'h5, 4'hA, 1'b0);
    chk("tr_sw_k8", 8'(sw0), 8'h0);
    step(4'h5, 4'hA, 1'b0);
    chk("tr_done_k9", 8'(done0), 8'h0);
    chk("tr_sw_k9", 8'(sw0), 8'h1);
    step(4'h5, 4'hA, 1'b0);
    chk("tr_done_k10", 8'(done0), 8'h1);
    chk("tr_sw_k10", 8'(sw0), 8'h1);
    chk("tr_busy_k10", 8'(busy0), 8'h0);
    chk("tr_fail_k10", 8'(fail0), 8'h0);
    for (int i = 0; i < 6; i++) begin
      step(4'(i + 2), 4'(12 - i), 1'b0);
      if (i >= 2) begin
        chk("swp_d1", 8'(d1_0), 8'(fh[n-4]));
        chk("swp_d2", 8'(d2_0), 8'(rh[n-3]));
      end
    end

    // Timeout with random data
    step(4'($urandom), 4'($urandom), 1'b1);
    chk("to_done_clr", 8'(done0), 8'h0);
    repeat (253) step(4'($urandom), 4'($urandom), 1'b0);
    step(4'($urandom), 4'($urandom), 1'b0);
    chk("to_busy_k254", 8'(busy0), 8'h1);
    step(4'($urandom), 4'($urandom), 1'b0);
    chk("to_fail_k255", 8'(fail0), 8'h0);
    chk("to_busy_k255", 8'(busy0), 8'h0);
    step(4'($urandom), 4'($urandom), 1'b0);
    chk("to_fail_k256", 8'(fail0), 8'h1);
    chk("to_done_k256", 8'(done0), 8'h0);
    chk("to_sw_k256", 8'(sw0), 8'h1);

    // Both pairings match at once on u1 (pattern AA): normal pairing wins
    repeat (4) step(4'hA, 4'hA, 1'b0);
    step(4'hA, 4'hA, 1'b1);
    chk("tie_fail_clr", 8'(fail1), 8'h0);
    repeat (9) step(4'hA, 4'hA, 1'b0);
    chk("tie_done_k9", 8'(done1), 8'h0);
    step(4'hA, 4'hA, 1'b0);
    chk("tie_done", 8'(done1), 8'h1);
    chk("tie_sw", 8'(sw1), 8'h0);
    chk("tie_busy", 8'(busy1), 8'h0);
    chk("u0_searching", 8'(busy0), 8'h1);

    // sset forces ones without disturbing the FSM, then reset lands mid-search
    sset = 1'b1;
    step(4'h3, 4'hC, 1'b0);
    chk("sset_d1", 8'(d1_0), 8'hF);
    chk("sset_d2", 8'(d2_0), 8'hF);
    chk("sset_busy", 8'(busy0), 8'h1);
    aclr_n = 1'b0;
    #1;
    chk("arst_d1", 8'(d1_0), 8'h0);
    chk("arst_d2", 8'(d2_0), 8'h0);
    chk("arst_sw", 8'(sw0), 8'h0);
    chk("arst_busy", 8'(busy0), 8'h0);
    chk("arst_done", 8'(done0), 8'h0);
    chk("arst_fail", 8'(fail0), 8'h0);
    @(negedge clock);
    @(negedge clock);
    #2;
    aclr_n = 1'b1;
    #1;
    chk("rel_d1", 8'(d1_0), 8'h0);
    step(4'h3, 4'hC, 1'b0);
    chk("rel_sset_d1", 8'(d1_0), 8'hF);
    chk("rel_sset_d2", 8'(d2_0), 8'hF);
    chk("rel_busy", 8'(busy0), 8'h0);
    repeat (2) step(4'h3, 4'hC, 1'b0);
    chk("rel_done", 8'(done0), 8'h0);
    chk("rel_fail", 8'(fail0), 8'h0);
    sset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
